mini_alu_pipe: RTL and testbench
================================

Name: mini_alu_pipe

Overview:
- Parametrised successor to the team's MiniAlu: a two-stage (fetch/decode, execute) accumulator-less register-register core.
- Instruction ROM is external, driven by oIP/iInstruction. Register file, forwarding, branch flush, call/return stack and LED output register are internal.
- Adds over the previous generation:
  - Width and depth generics.
  - SUB, SMUL, SHL, SHR, CALL and RET opcodes.
  - Explicit branch flush.
  - A sticky stack-error flag.

Parameters:
- DATA_W, 16, register and ALU data width.
- ADDR_W, 8, register-address field width. Register file depth is 2**ADDR_W.
- IP_W, 16, instruction pointer width (must be >= ADDR_W).
- LED_W, 8, LED output width (must be <= DATA_W).
- STACK_DEPTH, 4, return-address stack entries (power of two, >= 2).

Ports:
- Clock, in, 1, single clock; all state updates on posedge.
- Reset, in, 1, synchronous, active-high.
- oIP, out, IP_W, instruction pointer to the external combinational ROM.
- iInstruction, in, 4+3*ADDR_W, instruction word at oIP. Fields, MSB first: op[4], dst[ADDR_W], src1[ADDR_W], src0[ADDR_W].
- oLed, out, LED_W, registered LED value.
- oStackError, out, 1, sticky flag: CALL on full stack or RET on empty stack.

Behaviour:
- Reset: applied at the posedge while Reset=1.
  - Cleared to zero: PC (oIP), oLed, stack pointer, oStackError.
  - The decode register is loaded with NOP.
  - Register file contents are not reset; programs must STO before reading.
  - Reset asserted mid-program aborts the in-flight instruction: no RF write, no LED update, no stack change on that edge.
- Fetch/decode (stage 1):
  - Each posedge latches iInstruction and the current PC into the decode register.
  - Operands are read from the RF at the same edge.
  - PC <= PC+1, wrapping modulo 2**IP_W.
- Write-through bypass: if the RF write address equals a read address on the same edge, the captured operand is the value being written. Result: back-to-back dependent instructions need no stall.
- Execute (stage 2): combinational from the decode register.
  - RF write occurs at the posedge ending the execute cycle.
  - Latency is 1 cycle from the instruction entering execute to the RF write.
  - Immediate imm = {src1,src0}, zero-extended or truncated to DATA_W.
- Opcodes:
  - 0 NOP.
  - 1 LED: oLed <= R[src1][LED_W-1:0].
  - 2 BLE: branch to dst if R[src1] <= R[src0], unsigned.
  - 3 STO: R[dst] <= imm.
  - 4 ADD: R[dst] <= R[src1]+R[src0].
  - 5 JMP: unconditional branch to dst.
  - 6 SUB: R[dst] <= R[src1]-R[src0].
  - 7 SMUL: R[dst] <= low DATA_W bits of signed R[src1]*R[src0].
  - 8 CALL: push PC_ex+1, then branch to dst.
  - 9 RET: pop, then branch to the popped address.
  - 10 SHL: R[dst] <= R[src1] << R[src0][log2(DATA_W)-1:0].
  - 11 SHR: R[dst] <= R[src1] >> R[src0][log2(DATA_W)-1:0], logical.
  - 12..15: treated as NOP; no LED update.
  - All arithmetic wraps modulo 2**DATA_W; there are no flags.
- Branch (taken BLE, JMP, CALL, RET):
  - At the posedge ending execute, PC <= target, with dst zero-extended to IP_W.
  - The decode register loads NOP instead of iInstruction (flush), so the penalty is 1 bubble.
  - The flushed instruction has no side effect.
- Stack: STACK_DEPTH entries of IP_W bits, with pointer sp in the range 0..STACK_DEPTH.
  - CALL with sp==STACK_DEPTH: oStackError <= 1, executes as NOP (no push, no branch).
  - RET with sp==0: oStackError <= 1, executes as NOP.
  - Push and pop of the same entry cannot occur in one cycle (single execute slot).
  - oStackError clears only on Reset.
- Branch to current PC (e.g. "JMP to self") is legal and loops forever.
- PC wrap from 2**IP_W-1 to 0 is silent.

Test Plan:
- Reset, then ROM: STO R1,5; STO R2,7; ADD R3,R1,R2; LED R3 -> oLed==12 on the 5th posedge after Reset falls. Dependent ADD and LED need no stall (bypass check).
- Branch flush: STO R1,3; STO R2,3; BLE ->addr 6 (R1<=R2); at addr 4, LED of a register holding 0xAA; at addr 6, LED of R1 -> oLed never 0xAA and ends at 3; oIP sequence shows exactly one bubble.
- SUB/SMUL/shift checks:
  - 2-5 -> 0xFFFD.
  - SMUL 0xFFFE * 3 -> 0xFFFA.
  - SHL 1 by 17 -> 2 (mask to 4 bits).
  - SHR 0x8000 by 15 -> 1.
- Stack depth 4: five nested CALLs -> oStackError rises on the 5th and the 5th does not branch. Four RETs return to the correct addresses; a 5th RET keeps oStackError=1 and does not branch.
- Reset asserted in the cycle a CALL is in execute -> sp==0, oIP==0, oLed==0, oStackError==0 next cycle; the program restarts cleanly.
- Parameter sweep DATA_W=8, ADDR_W=4, IP_W=8, LED_W=4: ADD 0xF0+0x20 -> 0x10; LED shows 0x0.

Source files
------------

// File: rtl/mini_alu_pipe_if.sv
// rtl/mini_alu_pipe_if.sv - ROM fetch and status bus of the two-stage mini ALU core
interface mini_alu_pipe_if #(
    parameter int ADDR_W = 8,
    parameter int IP_W   = 16,
    parameter int LED_W  = 8
);
    logic [IP_W-1:0]       oIP;
    logic [4+3*ADDR_W-1:0] iInstruction;
    logic [LED_W-1:0]      oLed;
    logic                  oStackError;

    modport master (
        output oIP,
        output oLed,
        output oStackError,
        input  iInstruction
    );

    modport slave (
        input  oIP,
        input  oLed,
        input  oStackError,
        output iInstruction
    );
endinterface

// File: rtl/mini_alu_pipe.sv
// rtl/mini_alu_pipe.sv - two-stage register-register core with call stack and LED register
module mini_alu_pipe #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int IP_W        = 16,
    parameter int LED_W       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    mini_alu_pipe_if.master  bus
);
    localparam int SH_W = $clog2(DATA_W);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LED  = 4'd1;
    localparam logic [3:0] OP_BLE  = 4'd2;
    localparam logic [3:0] OP_STO  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SMUL = 4'd7;
    localparam logic [3:0] OP_CALL = 4'd8;
    localparam logic [3:0] OP_RET  = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_SHR  = 4'd11;

    logic [DATA_W-1:0] regFile [2**ADDR_W];
    logic [IP_W-1:0]   retStack [STACK_DEPTH];

    logic [IP_W-1:0]   pc;
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   spDec;
    logic [LED_W-1:0]  ledReg;
    logic              stackErr;

    // Fields of the word currently presented by the ROM
    logic [3:0]        fOp;
    logic [ADDR_W-1:0] fDst;
    logic [ADDR_W-1:0] fSrc1;
    logic [ADDR_W-1:0] fSrc0;

    // Decode register: instruction, its PC and its captured operands
    logic [3:0]        dOp;
    logic [ADDR_W-1:0] dDst;
    logic [ADDR_W-1:0] dSrc1;
    logic [ADDR_W-1:0] dSrc0;
    logic [IP_W-1:0]   dPc;
    logic [DATA_W-1:0] dA;
    logic [DATA_W-1:0] dB;

    // Execute-stage results
    logic              wrEn;
    logic [DATA_W-1:0] wrData;
    logic              taken;
    logic [IP_W-1:0]   target;
    logic              push;
    logic              pop;
    logic              ledEn;
    logic              errSet;

    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] mulLo;
    logic [SH_W-1:0]   shAmt;
    logic [IP_W-1:0]   retAddr;
    logic [IP_W-1:0]   dstIp;

    assign {fOp, fDst, fSrc1, fSrc0} = bus.iInstruction;

    assign spDec   = sp - 1'b1;
    assign imm     = DATA_W'({dSrc1, dSrc0});
    // Low half of a product is the same for signed and unsigned operands
    assign mulLo   = DATA_W'($signed(dA) * $signed(dB));
    assign shAmt   = dB[SH_W-1:0];
    assign retAddr = dPc + IP_W'(1);
    assign dstIp   = IP_W'(dDst);

    always_comb begin
        wrEn   = 1'b0;
        wrData = '0;
        taken  = 1'b0;
        target = dstIp;
        push   = 1'b0;
        pop    = 1'b0;
        ledEn  = 1'b0;
        errSet = 1'b0;
        case (dOp)
            OP_LED:  ledEn = 1'b1;
            OP_BLE:  taken = (dA <= dB);
            OP_STO:  begin wrEn = 1'b1; wrData = imm;      end
            OP_ADD:  begin wrEn = 1'b1; wrData = dA + dB;  end
            OP_JMP:  taken = 1'b1;
            OP_SUB:  begin wrEn = 1'b1; wrData = dA - dB;  end
            OP_SMUL: begin wrEn = 1'b1; wrData = mulLo;    end
            OP_CALL: begin
                if (sp == SP_FULL) begin
                    errSet = 1'b1;
                end else begin
                    push  = 1'b1;
                    taken = 1'b1;
                end
            end
            OP_RET: begin
                if (sp == '0) begin
                    errSet = 1'b1;
                end else begin
                    pop    = 1'b1;
                    taken  = 1'b1;
                    target = retStack[spDec[SP_W-2:0]];
                end
            end
            OP_SHL:  begin wrEn = 1'b1; wrData = dA << shAmt; end
            OP_SHR:  begin wrEn = 1'b1; wrData = dA >> shAmt; end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc       <= '0;
            dOp      <= OP_NOP;
            sp       <= '0;
            ledReg   <= '0;
            stackErr <= 1'b0;
        end else begin
            pc  <= taken ? target : pc + IP_W'(1);
            // A taken branch squashes the instruction being fetched
            dOp <= taken ? OP_NOP : fOp;
            if (ledEn) begin
                ledReg <= dA[LED_W-1:0];
            end
            if (push) begin
                sp <= sp + 1'b1;
            end else if (pop) begin
                sp <= spDec;
            end
            if (errSet) begin
                stackErr <= 1'b1;
            end
        end
    end

    // Operand capture with write-through so dependent neighbours need no stall
    always_ff @(posedge Clock) begin
        dDst  <= fDst;
        dSrc1 <= fSrc1;
        dSrc0 <= fSrc0;
        dPc   <= pc;
        dA    <= (wrEn && !Reset && fSrc1 == dDst) ? wrData : regFile[fSrc1];
        dB    <= (wrEn && !Reset && fSrc0 == dDst) ? wrData : regFile[fSrc0];
    end

    always_ff @(posedge Clock) begin
        if (!Reset && wrEn) begin
            regFile[dDst] <= wrData;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset && push) begin
            retStack[sp[SP_W-2:0]] <= retAddr;
        end
    end

    assign bus.oIP         = pc;
    assign bus.oLed        = ledReg;
    assign bus.oStackError = stackErr;
endmodule

// File: tb/tb_mini_alu_pipe.sv
// tb/tb_mini_alu_pipe.sv - directed programs checked against an instruction-level model
module tb_mini_alu_pipe;
    logic clk;
    logic rst;
    logic rst2;

    int nTests;
    int nFail;
    int edges;
    bit chkEn;
    bit recEn;
    bit seenAA;
    logic [7:0] prevLed;
    logic [7:0] ledLog [$];

    logic [27:0] rom  [65536];
    logic [15:0] rom2 [256];

    mini_alu_pipe_if #(.ADDR_W(8), .IP_W(16), .LED_W(8)) bus ();
    mini_alu_pipe_if #(.ADDR_W(4), .IP_W(8),  .LED_W(4)) bus2 ();

    mini_alu_pipe #(.DATA_W(16), .ADDR_W(8), .IP_W(16), .LED_W(8), .STACK_DEPTH(4)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    mini_alu_pipe #(.DATA_W(8), .ADDR_W(4), .IP_W(8), .LED_W(4), .STACK_DEPTH(4)) dut2 (
        .Clock (clk),
        .Reset (rst2),
        .bus   (bus2)
    );

    assign bus.iInstruction  = rom[bus.oIP];
    assign bus2.iInstruction = rom2[bus2.oIP];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [27:0] ins(input int op, input int dst, input int s1, input int s0);
        return {op[3:0], dst[7:0], s1[7:0], s0[7:0]};
    endfunction

    function automatic logic [27:0] sto(input int dst, input int imm);
        return ins(3, dst, imm >> 8, imm & 255);
    endfunction

    function automatic logic [15:0] ins2(input int op, input int dst, input int s1, input int s0);
        return {op[3:0], dst[3:0], s1[3:0], s0[3:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Instruction-level model: one instruction per cycle, taken branch costs one empty slot
    int unsigned mR [256];
    int unsigned mStack [4];
    int unsigned mFetch;
    int unsigned mExecPc;
    int unsigned mLed;
    int unsigned mSp;
    int unsigned mErr;
    bit          mValid;

    task automatic modelStep();
        logic [27:0] w;
        int unsigned op, dst, s1, s0, a, b, tgt;
        int sa, sb;
        bit taken;
        taken = 1'b0;
        tgt   = 0;
        if (mValid) begin
            w   = rom[mExecPc];
            op  = 32'(w[27:24]);
            dst = 32'(w[23:16]);
            s1  = 32'(w[15:8]);
            s0  = 32'(w[7:0]);
            a   = mR[s1];
            b   = mR[s0];
            case (op)
                1:  mLed = a & 32'hFF;
                2:  if (a <= b) begin taken = 1'b1; tgt = dst; end
                3:  mR[dst] = (s1 << 8) | s0;
                4:  mR[dst] = (a + b) & 32'hFFFF;
                5:  begin taken = 1'b1; tgt = dst; end
                6:  mR[dst] = (a - b) & 32'hFFFF;
                7:  begin
                    sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
                    sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
                    mR[dst] = 32'(sa * sb) & 32'hFFFF;
                end
                8:  if (mSp == 4) mErr = 1;
                    else begin
                        mStack[mSp] = (mExecPc + 1) & 32'hFFFF;
                        mSp++;
                        taken = 1'b1;
                        tgt = dst;
                    end
                9:  if (mSp == 0) mErr = 1;
                    else begin
                        mSp--;
                        taken = 1'b1;
                        tgt = mStack[mSp];
                    end
                10: mR[dst] = (a << (b % 16)) & 32'hFFFF;
                11: mR[dst] = a >> (b % 16);
                default: ;
            endcase
        end
        if (taken) begin
            mFetch = tgt;
            mValid = 1'b0;
        end else begin
            mExecPc = mFetch;
            mValid  = 1'b1;
            mFetch  = (mFetch + 1) & 32'hFFFF;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mFetch = 0;
            mLed   = 0;
            mSp    = 0;
            mErr   = 0;
            mValid = 1'b0;
        end else begin
            modelStep();
        end
    end

    always @(negedge clk) begin
        if (chkEn) begin
            check("cmp oIP", 32'(bus.oIP), mFetch);
            check("cmp oLed", 32'(bus.oLed), mLed);
            check("cmp oStackError", 32'(bus.oStackError), mErr);
            if (bus.oLed == 8'hAA) seenAA = 1'b1;
        end
        if (recEn) begin
            if (bus.oLed != prevLed) ledLog.push_back(bus.oLed);
            prevLed = bus.oLed;
        end
    end

    task automatic beginLoad();
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 65536; i++) rom[i] = '0;
    endtask

    task automatic go();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst    = 1'b0;
        edges  = 0;
        chkEn  = 1'b1;
        seenAA = 1'b0;
    endtask

    task automatic stepTo(input int k);
        while (edges < k) begin
            @(posedge clk);
            edges++;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] expLed [6];
        nTests = 0;
        nFail  = 0;
        edges  = 0;
        chkEn  = 1'b0;
        recEn  = 1'b0;
        seenAA = 1'b0;
        prevLed = '0;
        rst  = 1'b1;
        rst2 = 1'b1;
        for (int i = 0; i < 256; i++) rom2[i] = '0;

        // Reset state
        beginLoad();
        @(posedge clk);
        @(negedge clk);
        check("reset oIP", 32'(bus.oIP), 0);
        check("reset oLed", 32'(bus.oLed), 0);
        check("reset oStackError", 32'(bus.oStackError), 0);

        // Dependent ADD and LED with no stall
        rom[0] = sto(1, 5);
        rom[1] = sto(2, 7);
        rom[2] = ins(4, 3, 1, 2);
        rom[3] = ins(1, 0, 3, 0);
        rom[4] = ins(5, 4, 0, 0);
        go();
        stepTo(4);
        check("bypass led before", 32'(bus.oLed), 0);
        stepTo(5);
        check("bypass led 12", 32'(bus.oLed), 12);
        check("bypass oIP", 32'(bus.oIP), 5);
        stepTo(12);

        // Branch flush
        beginLoad();
        rom[0] = sto(4, 8'hAA);
        rom[1] = sto(1, 3);
        rom[2] = sto(2, 3);
        rom[3] = ins(2, 6, 1, 2);
        rom[4] = ins(1, 0, 4, 0);
        rom[5] = ins(1, 0, 4, 0);
        rom[6] = ins(1, 0, 1, 0);
        rom[7] = ins(5, 7, 0, 0);
        go();
        begin
            int expIp [8] = '{1, 2, 3, 4, 6, 7, 8, 7};
            for (int i = 0; i < 8; i++) begin
                stepTo(i + 1);
                check($sformatf("branch oIP@%0d", i + 1), 32'(bus.oIP), expIp[i]);
                if (i == 5) check("branch bubble led", 32'(bus.oLed), 0);
                if (i == 6) check("branch led 3", 32'(bus.oLed), 3);
            end
        end
        stepTo(16);
        check("branch no 0xAA", 32'(seenAA), 0);
        check("branch final led", 32'(bus.oLed), 3);

        // SUB / SMUL / shifts, observed through the LED
        beginLoad();
        rom[0]  = sto(1, 2);
        rom[1]  = sto(2, 5);
        rom[2]  = ins(6, 3, 1, 2);
        rom[3]  = ins(1, 0, 3, 0);
        rom[4]  = sto(9, 8);
        rom[5]  = ins(11, 4, 3, 9);
        rom[6]  = ins(1, 0, 4, 0);
        rom[7]  = sto(5, 16'hFFFE);
        rom[8]  = sto(6, 3);
        rom[9]  = ins(7, 7, 5, 6);
        rom[10] = ins(1, 0, 7, 0);
        rom[11] = ins(11, 8, 7, 9);
        rom[12] = ins(1, 0, 8, 0);
        rom[13] = sto(10, 1);
        rom[14] = sto(11, 17);
        rom[15] = ins(10, 12, 10, 11);
        rom[16] = ins(1, 0, 12, 0);
        rom[17] = sto(13, 16'h8000);
        rom[18] = sto(14, 15);
        rom[19] = ins(11, 15, 13, 14);
        rom[20] = ins(1, 0, 15, 0);
        rom[21] = ins(5, 21, 0, 0);
        go();
        prevLed = '0;
        ledLog.delete();
        recEn = 1'b1;
        stepTo(30);
        recEn = 1'b0;
        expLed = '{8'hFD, 8'hFF, 8'hFA, 8'hFF, 8'h02, 8'h01};
        check("alu led count", ledLog.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < ledLog.size())
                check($sformatf("alu led[%0d]", i), 32'(ledLog[i]), 32'(expLed[i]));
        end

        // Five nested CALLs, five RETs
        beginLoad();
        rom[0]  = ins(8, 10, 0, 0);
        rom[10] = ins(8, 20, 0, 0);
        rom[20] = ins(8, 30, 0, 0);
        rom[30] = ins(8, 40, 0, 0);
        rom[40] = ins(8, 50, 0, 0);
        rom[41] = ins(9, 0, 0, 0);
        rom[31] = ins(9, 0, 0, 0);
        rom[21] = ins(9, 0, 0, 0);
        rom[11] = ins(9, 0, 0, 0);
        rom[1]  = ins(9, 0, 0, 0);
        rom[2]  = ins(5, 2, 0, 0);
        go();
        stepTo(9);
        check("stack err before 5th", 32'(bus.oStackError), 0);
        stepTo(10);
        check("stack err on 5th", 32'(bus.oStackError), 1);
        check("stack 5th no branch", 32'(bus.oIP), 42);
        stepTo(11);
        check("stack ret1", 32'(bus.oIP), 31);
        stepTo(13);
        check("stack ret2", 32'(bus.oIP), 21);
        stepTo(15);
        check("stack ret3", 32'(bus.oIP), 11);
        stepTo(17);
        check("stack ret4", 32'(bus.oIP), 1);
        stepTo(19);
        check("stack ret5 no branch", 32'(bus.oIP), 3);
        check("stack err sticky", 32'(bus.oStackError), 1);
        stepTo(22);
        check("stack loop", 32'(bus.oIP), 2);

        // Reset while a CALL is in execute
        beginLoad();
        rom[0] = ins(9, 0, 0, 0);
        rom[1] = sto(1, 8'h5A);
        rom[2] = ins(1, 0, 1, 0);
        rom[3] = ins(8, 6, 0, 0);
        rom[6] = ins(8, 9, 0, 0);
        rom[9] = ins(9, 0, 0, 0);
        rom[7] = ins(9, 0, 0, 0);
        rom[4] = ins(9, 0, 0, 0);
        rom[5] = ins(5, 5, 0, 0);
        go();
        stepTo(2);
        check("rst-call err set", 32'(bus.oStackError), 1);
        stepTo(4);
        check("rst-call led", 32'(bus.oLed), 8'h5A);
        stepTo(6);
        rst = 1'b1;
        stepTo(7);
        check("rst-call oIP", 32'(bus.oIP), 0);
        check("rst-call oLed", 32'(bus.oLed), 0);
        check("rst-call err", 32'(bus.oStackError), 0);
        rst   = 1'b0;
        edges = 0;
        stepTo(11);
        check("restart ret", 32'(bus.oIP), 4);
        stepTo(13);
        check("restart empty ret", 32'(bus.oIP), 6);
        stepTo(14);
        check("restart loop", 32'(bus.oIP), 5);

        // Narrow configuration
        @(posedge clk);
        #2;
        rom2[0] = ins2(3, 1, 4'hF, 4'h0);
        rom2[1] = ins2(3, 2, 4'h2, 4'h0);
        rom2[2] = ins2(3, 5, 4'h0, 4'h4);
        rom2[3] = ins2(4, 3, 1, 2);
        rom2[4] = ins2(1, 0, 3, 0);
        rom2[5] = ins2(11, 4, 3, 5);
        rom2[6] = ins2(1, 0, 4, 0);
        rom2[7] = ins2(5, 7, 0, 0);
        @(posedge clk);
        @(negedge clk);
        check("w8 reset oIP", 32'(bus2.oIP), 0);
        @(posedge clk);
        #2;
        rst2  = 1'b0;
        edges = 0;
        stepTo(6);
        check("w8 led wrap 0", 32'(bus2.oLed), 0);
        stepTo(8);
        check("w8 led sum>>4", 32'(bus2.oLed), 1);
        stepTo(9);
        check("w8 loop oIP", 32'(bus2.oIP), 7);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
